// File: rtl/mu_migration_router_pkg.sv
// Shared types and widths for the motion-update migration router.
package MD_pkg;
  localparam int MU_ID_WIDTH = 6;

  typedef struct packed {
    logic [MU_ID_WIDTH-1:0] dst_id;
    logic [7:0]             element;
    logic [87:0]            vel;
    logic [95:0]            offset;
  } mu_pkt_t;

  localparam int MU_PKT_STRUCT_WIDTH  = $bits(mu_pkt_t);
  // Payload on the wire is the packet minus its routing id.
  localparam int MU_PAYLOAD_WIDTH     = MU_PKT_STRUCT_WIDTH - MU_ID_WIDTH;
  localparam int DEFAULT_STARVE_LIMIT = 8;
endpackage

// File: rtl/mu_migration_router_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers,
// almost-full threshold and a per-cycle overflow pulse.
module mu_sync_fifo #(
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         almost_full,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_MARGIN);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic         full, do_rd, do_wr;

  always_comb begin
    count       = wr_ptr_q - rd_ptr_q;
    empty       = (count == '0);
    full        = (count == DEPTH_C);
    almost_full = ((DEPTH_C - count) <= AF_C);
    do_rd       = rd_en && !empty;
    // A read in the same cycle frees the slot, so a full FIFO may still accept.
    do_wr       = wr_en && (!full || do_rd);
    overflow    = wr_en && full && !do_rd;
    wr_ptr_d    = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(do_rd);
    rd_data     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk)
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
endmodule

// File: rtl/mu_migration_router.sv
// Merges local migrated packets (via FIFO) with the migration ring; dual-grant
// arbiter with starvation bound. Optional counters under MU_ROUTER_STATS_EN.
module mu_migration_router import MD_pkg::*; #(
  parameter int PAYLOAD_W    = MU_PAYLOAD_WIDTH,
  parameter int ID_W         = MU_ID_WIDTH,
  parameter int LOCAL_ID     = 0,
  parameter int FIFO_DEPTH   = 16,
  parameter int AF_MARGIN    = 4,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W-1:0] i_new_payload,
  input  logic [ID_W-1:0]      i_new_dst_id,
  input  logic                 i_new_valid,
  input  logic [PAYLOAD_W-1:0] i_ring_payload,
  input  logic [ID_W-1:0]      i_ring_dst_id,
  input  logic                 i_ring_valid,
  output logic                 o_ring_ready,
  output logic [PAYLOAD_W-1:0] o_ring_payload,
  output logic [ID_W-1:0]      o_ring_dst_id,
  output logic                 o_ring_valid,
  input  logic                 i_ring_out_ready,
  output logic [PAYLOAD_W-1:0] o_local_payload,
  output logic                 o_local_valid,
  output logic                 o_buf_almost_full,
  output logic                 o_buf_empty,
  output logic                 o_overflow_err
`ifdef MU_ROUTER_STATS_EN
  ,
  output logic [31:0]          o_stat_returned,
  output logic [31:0]          o_stat_forwarded,
  output logic [31:0]          o_stat_starve_forced
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   LIM   = SW'(STARVE_LIMIT);
  localparam logic [ID_W-1:0] LOCAL = ID_W'(LOCAL_ID);

  logic [PAYLOAD_W-1:0] f_pay;
  logic [ID_W-1:0]      f_dst;
  logic                 f_empty, f_ovf;
  logic r_v, f_v, r_loc, f_loc, ring_free, gnt_r, gnt_f, forced;

  logic [PAYLOAD_W-1:0] local_payload_q, local_payload_d, ring_payload_q, ring_payload_d;
  logic [ID_W-1:0]      ring_dst_q, ring_dst_d;
  logic                 local_valid_q, local_valid_d, ring_valid_q, ring_valid_d;
  logic                 ovf_q, ovf_d;
  logic [SW-1:0]        starve_q, starve_d;

  mu_sync_fifo #(.W(ID_W + PAYLOAD_W), .DEPTH(FIFO_DEPTH), .AF_MARGIN(AF_MARGIN)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (i_new_valid),
    .wr_data    ({i_new_dst_id, i_new_payload}),
    .rd_en      (gnt_f),
    .rd_data    ({f_dst, f_pay}),
    .empty      (f_empty),
    .almost_full(o_buf_almost_full),
    .overflow   (f_ovf)
  );

  always_comb begin
    r_v       = i_ring_valid && !rst;
    f_v       = !f_empty && !rst;
    r_loc     = (i_ring_dst_id == LOCAL);
    f_loc     = (f_dst == LOCAL);
    ring_free = !ring_valid_q || i_ring_out_ready;
    gnt_r     = 1'b0;
    gnt_f     = 1'b0;
    forced    = 1'b0;
    if (r_v && f_v && (r_loc == f_loc)) begin
      // Contention for one sink: ring has priority until the FIFO has starved.
      if (r_loc || ring_free) begin
        if (starve_q == LIM) begin
          gnt_f  = 1'b1;
          forced = 1'b1;
        end else begin
          gnt_r  = 1'b1;
        end
      end
    end else begin
      gnt_r = r_v && (r_loc || ring_free);
      gnt_f = f_v && (f_loc || ring_free);
    end

    local_valid_d   = (gnt_r && r_loc) || (gnt_f && f_loc);
    local_payload_d = local_payload_q;
    if (gnt_r && r_loc)      local_payload_d = i_ring_payload;
    else if (gnt_f && f_loc) local_payload_d = f_pay;

    ring_valid_d   = ring_valid_q && !i_ring_out_ready;
    ring_payload_d = ring_payload_q;
    ring_dst_d     = ring_dst_q;
    if (gnt_r && !r_loc) begin
      ring_valid_d   = 1'b1;
      ring_payload_d = i_ring_payload;
      ring_dst_d     = i_ring_dst_id;
    end else if (gnt_f && !f_loc) begin
      ring_valid_d   = 1'b1;
      ring_payload_d = f_pay;
      ring_dst_d     = f_dst;
    end

    starve_d = starve_q;
    if (!f_v || gnt_f)      starve_d = '0;
    else if (starve_q != LIM) starve_d = starve_q + 1'b1;

    ovf_d = ovf_q || f_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      local_payload_q <= '0;
      local_valid_q   <= 1'b0;
      ring_payload_q  <= '0;
      ring_dst_q      <= '0;
      ring_valid_q    <= 1'b0;
      starve_q        <= '0;
      ovf_q           <= 1'b0;
    end else begin
      local_payload_q <= local_payload_d;
      local_valid_q   <= local_valid_d;
      ring_payload_q  <= ring_payload_d;
      ring_dst_q      <= ring_dst_d;
      ring_valid_q    <= ring_valid_d;
      starve_q        <= starve_d;
      ovf_q           <= ovf_d;
    end
  end

  assign o_ring_ready    = gnt_r;
  assign o_ring_payload  = ring_payload_q;
  assign o_ring_dst_id   = ring_dst_q;
  assign o_ring_valid    = ring_valid_q;
  assign o_local_payload = local_payload_q;
  assign o_local_valid   = local_valid_q;
  assign o_buf_empty     = f_empty;
  assign o_overflow_err  = ovf_q;

`ifdef MU_ROUTER_STATS_EN
  logic [31:0] st_ret_q, st_ret_d, st_fwd_q, st_fwd_d, st_frc_q, st_frc_d;

  always_comb begin
    st_ret_d = st_ret_q;
    st_fwd_d = st_fwd_q;
    st_frc_d = st_frc_q;
    if (local_valid_d && st_ret_q != '1)        st_ret_d = st_ret_q + 1;
    if (gnt_f && !f_loc && st_fwd_q != '1)      st_fwd_d = st_fwd_q + 1;
    if (forced && st_frc_q != '1)               st_frc_d = st_frc_q + 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_ret_q <= '0;
      st_fwd_q <= '0;
      st_frc_q <= '0;
    end else begin
      st_ret_q <= st_ret_d;
      st_fwd_q <= st_fwd_d;
      st_frc_q <= st_frc_d;
    end
  end

  assign o_stat_returned      = st_ret_q;
  assign o_stat_forwarded     = st_fwd_q;
  assign o_stat_starve_forced = st_frc_q;
`endif
endmodule

// File: tb/tb_mu_migration_router.sv
// Directed scoreboard bench for mu_migration_router (LOCAL_ID=0, depth 16, limit 8).
module tb_mu_migration_router;
  localparam int PW = 192;
  localparam int IW = 6;
  typedef logic [IW+PW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [PW-1:0] i_new_payload, i_ring_payload, o_ring_payload, o_local_payload;
  logic [IW-1:0] i_new_dst_id, i_ring_dst_id, o_ring_dst_id;
  logic i_new_valid, i_ring_valid, o_ring_ready, o_ring_valid, i_ring_out_ready;
  logic o_local_valid, o_buf_almost_full, o_buf_empty, o_overflow_err;
`ifdef MU_ROUTER_STATS_EN
  logic [31:0] o_stat_returned, o_stat_forwarded, o_stat_starve_forced;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  ent_t          ring_q[$];
  logic [PW-1:0] local_q[$];

  always #5 clk = ~clk;

  mu_migration_router #(.PAYLOAD_W(PW), .ID_W(IW), .LOCAL_ID(0), .FIFO_DEPTH(16),
                        .AF_MARGIN(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .i_new_payload(i_new_payload), .i_new_dst_id(i_new_dst_id), .i_new_valid(i_new_valid),
    .i_ring_payload(i_ring_payload), .i_ring_dst_id(i_ring_dst_id), .i_ring_valid(i_ring_valid),
    .o_ring_ready(o_ring_ready), .o_ring_payload(o_ring_payload), .o_ring_dst_id(o_ring_dst_id),
    .o_ring_valid(o_ring_valid), .i_ring_out_ready(i_ring_out_ready),
    .o_local_payload(o_local_payload), .o_local_valid(o_local_valid),
    .o_buf_almost_full(o_buf_almost_full), .o_buf_empty(o_buf_empty),
    .o_overflow_err(o_overflow_err)
`ifdef MU_ROUTER_STATS_EN
    , .o_stat_returned(o_stat_returned), .o_stat_forwarded(o_stat_forwarded),
    .o_stat_starve_forced(o_stat_starve_forced)
`endif
  );

  function automatic logic [PW-1:0] pay(input int n);
    logic [31:0] w;
    w = 32'(n) * 32'h9E3779B1;
    return {w, ~w, w + 32'd1, w ^ 32'h5A5A5A5A, 32'(n), w - 32'd7};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on every local strobe and every accepted ring-out beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_local_valid) begin
        if (local_q.size() == 0) chk("local_unexpected", 256'(o_local_valid), 256'(0));
        else chk("local_payload", 256'(o_local_payload), 256'(local_q.pop_front()));
      end
      if (o_ring_valid && i_ring_out_ready) begin
        if (ring_q.size() == 0) chk("ring_unexpected", 256'(o_ring_valid), 256'(0));
        else chk("ring_pkt", 256'({o_ring_dst_id, o_ring_payload}), 256'(ring_q.pop_front()));
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; i_new_valid = 1'b0; i_new_payload = '0; i_new_dst_id = '0;
    i_ring_valid = 1'b1; i_ring_dst_id = 6'd5; i_ring_payload = pay(77);
    i_ring_out_ready = 1'b0;
    #2 chk("rst_ring_ready", 256'(o_ring_ready), 256'(0));
    cyc(); cyc();
    chk("rst_ring_valid",  256'(o_ring_valid), 256'(0));
    chk("rst_local_valid", 256'(o_local_valid), 256'(0));
    chk("rst_empty",       256'(o_buf_empty), 256'(1));
    chk("rst_af",          256'(o_buf_almost_full), 256'(0));
    chk("rst_ovf",         256'(o_overflow_err), 256'(0));
    chk("rst_ring_pay",    256'(o_ring_payload), 256'(0));
    i_ring_valid = 1'b0; rst = 1'b0; i_ring_out_ready = 1'b1;
    cyc();

    // Ring-through to a remote cell.
    i_ring_valid = 1'b1; i_ring_dst_id = 6'd5; i_ring_payload = pay(1);
    #1 chk("t1_ready", 256'(o_ring_ready), 256'(1));
    ring_q.push_back({6'd5, pay(1)});
    cyc(); i_ring_valid = 1'b0;
    chk("t1_out_valid", 256'(o_ring_valid), 256'(1));
    chk("t1_out_id", 256'(o_ring_dst_id), 256'(5));

    // Dual grant: ring->local and FIFO->ring in one cycle.
    i_new_valid = 1'b1; i_new_dst_id = 6'd3; i_new_payload = pay(2);
    cyc(); i_new_valid = 1'b0;
    chk("t2_not_empty", 256'(o_buf_empty), 256'(0));
    i_ring_valid = 1'b1; i_ring_dst_id = 6'd0; i_ring_payload = pay(3);
    #1 chk("t2_ready", 256'(o_ring_ready), 256'(1));
    local_q.push_back(pay(3));
    ring_q.push_back({6'd3, pay(2)});
    cyc(); i_ring_valid = 1'b0;
    chk("t2_local_valid", 256'(o_local_valid), 256'(1));
    chk("t2_ring_valid",  256'(o_ring_valid), 256'(1));
    cyc();
    chk("t2_local_strobe_end", 256'(o_local_valid), 256'(0));

    // Starvation: FIFO head loses 8 times, wins on the 9th contended cycle.
    i_new_valid = 1'b1; i_new_dst_id = 6'd9; i_new_payload = pay(9);
    cyc(); i_new_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      i_ring_valid = 1'b1; i_ring_dst_id = 6'd7; i_ring_payload = pay(100 + k);
      #1 chk($sformatf("t3_ready_c%0d", i), 256'(o_ring_ready), 256'(i != 9));
      if (i == 9) ring_q.push_back({6'd9, pay(9)});
      else begin ring_q.push_back({6'd7, pay(100 + k)}); k++; end
      cyc();
    end
    i_ring_valid = 1'b0;
    cyc(); cyc();

    // Downstream stall: output holds, ring sink blocked, FIFO fills to overflow.
    i_ring_out_ready = 1'b0;
    i_ring_valid = 1'b1; i_ring_dst_id = 6'd5; i_ring_payload = pay(200);
    #1 chk("t4_first_ready", 256'(o_ring_ready), 256'(1));
    ring_q.push_back({6'd5, pay(200)});
    cyc();
    for (int h = 1; h <= 5; h++) begin
      i_ring_payload = pay(201);
      i_new_valid = 1'b1; i_new_dst_id = 6'd6; i_new_payload = pay(300 + h);
      #1;
      chk("t4_hold_ready",   256'(o_ring_ready), 256'(0));
      chk("t4_hold_valid",   256'(o_ring_valid), 256'(1));
      chk("t4_hold_payload", 256'(o_ring_payload), 256'(pay(200)));
      cyc();
    end
    i_ring_valid = 1'b0;
    for (int w = 6; w <= 17; w++) begin
      i_new_valid = 1'b1; i_new_dst_id = 6'd6; i_new_payload = pay(300 + w);
      cyc();
      chk($sformatf("t5_af_w%0d", w),  256'(o_buf_almost_full), 256'(w >= 12));
      chk($sformatf("t5_ovf_w%0d", w), 256'(o_overflow_err), 256'(w >= 17));
    end
    i_new_valid = 1'b0;
    for (int e = 1; e <= 16; e++) ring_q.push_back({6'd6, pay(300 + e)});
    i_ring_out_ready = 1'b1;
    for (int d = 0; d < 18; d++) cyc();
    chk("t5_drained_empty", 256'(o_buf_empty), 256'(1));
    chk("t5_ovf_sticky",    256'(o_overflow_err), 256'(1));
    chk("t5_ring_q_done",   256'(ring_q.size()), 256'(0));

    // Reset mid-stream with FIFO entries and a stalled ring output.
    i_ring_out_ready = 1'b0;
    i_ring_valid = 1'b1; i_ring_dst_id = 6'd5; i_ring_payload = pay(400);
    i_new_valid = 1'b1; i_new_dst_id = 6'd5; i_new_payload = pay(500);
    cyc(); i_ring_valid = 1'b0; i_new_payload = pay(501);
    cyc(); i_new_payload = pay(502);
    cyc(); i_new_valid = 1'b0;
    chk("t6_pre_ring_valid", 256'(o_ring_valid), 256'(1));
    chk("t6_pre_not_empty",  256'(o_buf_empty), 256'(0));
    chk("t6_pre_starving",   256'(dut.starve_q != 0), 256'(1));
    rst = 1'b1;
    i_ring_valid = 1'b1; i_ring_dst_id = 6'd5; i_ring_payload = pay(401);
    #1 chk("t6_rst_ready", 256'(o_ring_ready), 256'(0));
    cyc();
    chk("t6_ring_valid",  256'(o_ring_valid), 256'(0));
    chk("t6_ring_pay",    256'(o_ring_payload), 256'(0));
    chk("t6_local_valid", 256'(o_local_valid), 256'(0));
    chk("t6_empty",       256'(o_buf_empty), 256'(1));
    chk("t6_af",          256'(o_buf_almost_full), 256'(0));
    chk("t6_ovf",         256'(o_overflow_err), 256'(0));
    chk("t6_starve",      256'(dut.starve_q), 256'(0));
    rst = 1'b0; i_ring_valid = 1'b0; i_ring_out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("t6_post_ring_valid", 256'(o_ring_valid), 256'(0));
    chk("t6_post_empty",      256'(o_buf_empty), 256'(1));
    chk("end_local_q",        256'(local_q.size()), 256'(0));
    chk("end_ring_q",         256'(ring_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mu_migration_router.md
Name: mu_migration_router

Overview:
- Parametrised successor to the per-cell motion-update return/forward logic.
- Accepts migrated particle packets from the local motion-update pipeline into a FIFO and merges them with the inter-cell migration ring.
- Delivers packets addressed to this cell to the local cache write port; forwards all others downstream on the ring.
- Adds over the previous generation: valid/ready backpressure on the ring, dual-grant when sources target different sinks, and starvation-bounded arbitration.

Parameters:
PAYLOAD_W, 192, packet payload bits (offset+vel+element).
ID_W, 6, destination MU id width.
LOCAL_ID, 0, MU id of this cell.
FIFO_DEPTH, 16, local FIFO entries; power of 2, ≥4.
AF_MARGIN, 4, almost-full asserted when free entries ≤ AF_MARGIN.
STARVE_LIMIT, 8, consecutive FIFO-loss cycles before the FIFO is forced to win; ≥1.

Ports:
clk  in  1  clock
rst  in  1  reset
i_new_payload  in  PAYLOAD_W  packet from motion update
i_new_dst_id  in  ID_W  destination MU id
i_new_valid  in  1  write strobe; no ready, producer throttles on almost-full
i_ring_payload  in  PAYLOAD_W  upstream ring packet
i_ring_dst_id  in  ID_W  upstream ring destination
i_ring_valid  in  1  upstream valid
o_ring_ready  out  1  upstream accepted this cycle
o_ring_payload  out  PAYLOAD_W  downstream ring packet
o_ring_dst_id  out  ID_W  downstream destination
o_ring_valid  out  1  downstream valid
i_ring_out_ready  in  1  downstream ready
o_local_payload  out  PAYLOAD_W  packet returned to this cell
o_local_valid  out  1  one-cycle strobe; sink always accepts
o_buf_almost_full  out  1  FIFO almost full
o_buf_empty  out  1  FIFO empty
o_overflow_err  out  1  sticky; write attempted while full

Behaviour:
- Single clock domain; synchronous active-high rst.
- Reset values: all outputs 0; FIFO empty, so o_buf_empty=1. Starve counter 0.
- Sources: R (ring-in, when i_ring_valid) and F (FIFO head, when not empty). Sink per source: LOCAL if dst_id==LOCAL_ID, else RING.
- LOCAL sink is always free. RING sink free = !o_ring_valid || i_ring_out_ready.
- Grant rules per cycle:
  - Sources target different sinks: grant both, subject to sink availability.
  - Same sink: R wins unless starve_cnt==STARVE_LIMIT, in which case F wins.
  - Sink not free: neither source targeting it is granted.
- o_ring_ready = R granted. Combinational from i_ring_valid/i_ring_dst_id/state; upstream must not combinationally loop valid on ready.
- FIFO read occurs when F is granted (first-word-fall-through head).
- Outputs are registered, 1-cycle latency from grant.
  - o_local_valid is high for exactly the cycle after a local grant, and low otherwise.
  - o_ring_valid/payload/id load on a ring grant. They hold while o_ring_valid && !i_ring_out_ready, and clear when consumed with no new grant.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when F is valid and not granted.
  - Clears on an F grant, or when the FIFO is empty.
  - Cycles where F's sink is busy count as losses.
- FIFO:
  - Write when i_new_valid && !full. Read and write in the same cycle are legal, including when full (read frees the slot first) and when empty (write only; head visible next cycle).
  - Write while full and not reading: packet dropped, o_overflow_err set until rst.
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit.
- Reset mid-operation: all in-flight packets discarded. o_ring_ready=0 during rst.

Optional Feature:
- Macro MU_ROUTER_STATS_EN.
- Defined: adds 32-bit saturating counters, each with an output port, cleared by rst:
  - o_stat_returned: local deliveries.
  - o_stat_forwarded: ring-out loads from F only.
  - o_stat_starve_forced: forced F wins.
- Undefined: ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package MD_pkg: MU_PKT_STRUCT_WIDTH-derived payload width, MU_ID_WIDTH, mu_pkt_t struct {dst_id, element, vel, offset}, and a default STARVE_LIMIT constant.
- Sub-module mu_sync_fifo (parametrised width/depth/margin, FWFT, empty/full/almost_full). Arbiter and output registers stay in the top.

Test Plan:
- Ring packet dst=5, LOCAL_ID=0, ready=1 -> o_ring_valid next cycle, id=5, same payload; o_ring_ready=1 in the input cycle.
- Ring packet dst=0 and FIFO head dst=3 in the same cycle -> both granted; next cycle o_local_valid=1 (ring payload) and o_ring_valid=1 (FIFO payload).
- Continuous ring traffic dst=7, FIFO head dst=9, STARVE_LIMIT=8 -> FIFO granted exactly on cycle 9; o_ring_ready=0 on that cycle.
- Hold i_ring_out_ready=0 for 5 cycles with a packet on o_ring -> output payload stable; no grants to RING; FIFO accepts writes until full.
- Write 17 packets into FIFO_DEPTH=16 with no reads:
  - o_buf_almost_full rises after write 12.
  - 17th packet dropped; o_overflow_err=1.
  - Drain yields 16 packets in order.
- Assert rst mid-stream with 3 FIFO entries and o_ring_valid=1 -> next cycle all outputs 0, o_buf_empty=1, starve counter 0.
